// File: rtl/qspi_bank_router_if.sv
// Host-side QSPI pins, per-bank IO lanes and the command log stream.
// The router attaches through the slave modport; the host/bench side uses master.
interface qspi_bank_router_if #(
  parameter int BANKS    = 2,
  parameter int SEL_BITS = $clog2(BANKS)
);
  logic                   spi_clk;
  logic                   spi_cs_in;
  logic [3:0]             spi_di;
  logic [3:0]             spi_do;
  logic [3:0]             spi_do_enable;
  logic [4*BANKS-1:0]     bank_di;
  logic [SEL_BITS-1:0]    bank_sel;
  logic [7:0]             log_data;
  logic                   log_valid;
  logic                   log_ready;
  logic                   log_overflow;

  modport slave (
    input  spi_clk, spi_cs_in, spi_di, bank_di, log_ready,
    output spi_do, spi_do_enable, bank_sel, log_data, log_valid, log_overflow
  );

  modport master (
    output spi_clk, spi_cs_in, spi_di, bank_di, log_ready,
    input  spi_do, spi_do_enable, bank_sel, log_data, log_valid, log_overflow
  );
endinterface

// File: rtl/qspi_bank_router.sv
// QSPI flash front end that decodes read/ID/status commands, routes the data
// phase from one of several RAM banks (chosen by the top address bits) and logs
// every command and address byte into a small FIFO.
module qspi_bank_router #(
  parameter int          ADDR_BITS    = 24,
  parameter int          BANKS        = 2,
  parameter logic [23:0] JEDEC_ID     = 24'hC22018,
  parameter int          DUMMY_CYCLES = 8,
  parameter int          LOG_DEPTH    = 16
) (
  input  logic              clk,
  input  logic              reset,
  qspi_bank_router_if.slave bus
);
  localparam int SEL_BITS = $clog2(BANKS);
  localparam int PTR_BITS = $clog2(LOG_DEPTH);
  localparam int CNT_W    = 16;
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
  localparam logic [1:0] LANES_1 = 2'd0;
  localparam logic [1:0] LANES_2 = 2'd1;
  localparam logic [1:0] LANES_4 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_RESP, ST_IGNORE
  } state_t;

  state_t                 state_r, state_next_s;
  logic                   spi_clk_q_r, cs_q_r;
  logic                   sck_rise_s, sck_fall_s;
  logic [6:0]             cmd_sh_r;
  logic [2:0]             bit_cnt_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [ADDR_BITS-1:0]   read_addr_r;
  logic [SEL_BITS-1:0]    bank_sel_r;
  logic                   wel_r, dummy_r, rdid_r;
  logic [1:0]             lanes_r;
  logic [7:0]             resp_sh_r;
  logic [1:0]             resp_idx_r;
  logic [2:0]             resp_bit_r;
  logic                   resp_skip_r;

  logic [7:0]             cmd_byte_s;
  logic [ADDR_BITS-1:0]   addr_next_s, addr_inc_s;
  logic                   addr_byte_done_s;
  logic                   dec_dummy_s, dec_rdid_s;
  logic [1:0]             dec_lanes_s;
  logic [2:0]             byte_last_s;
  logic                   log_push_s;
  logic [7:0]             log_byte_s;
  logic [3:0]             bank_slice_s, do_s, en_s;

  logic [7:0]             log_mem_r [LOG_DEPTH];
  logic [PTR_BITS:0]      wr_ptr_r, rd_ptr_r;
  logic                   log_overflow_r;
  logic                   empty_s, full_s, pop_s, push_ok_s;

  // Response byte for RDID (ID bytes then zeros) or RDSR (status with WEL).
  function automatic logic [7:0] resp_byte(input logic is_rdid, input logic [1:0] idx,
                                           input logic wel);
    logic [7:0] b;
    if (!is_rdid) begin
      b = {6'b000000, wel, 1'b0};
    end else begin
      case (idx)
        2'd0:    b = JEDEC_ID[23:16];
        2'd1:    b = JEDEC_ID[15:8];
        2'd2:    b = JEDEC_ID[7:0];
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  assign sck_rise_s       = bus.spi_clk & ~spi_clk_q_r;
  assign sck_fall_s       = ~bus.spi_clk & spi_clk_q_r;
  assign addr_byte_done_s = ((3'(ADDR_BITS - 1) - cnt_r[2:0]) == 3'd0);

  // Next-state decode, opcode decode and log push request.
  always_comb begin
    state_next_s = state_r;
    cmd_byte_s   = {cmd_sh_r, bus.spi_di[0]};
    addr_next_s  = {read_addr_r[ADDR_BITS-2:0], bus.spi_di[0]};
    addr_inc_s   = read_addr_r + ADDR_BITS'(1);
    log_push_s   = 1'b0;
    log_byte_s   = 8'h00;
    dec_dummy_s  = 1'b0;
    dec_lanes_s  = LANES_1;
    dec_rdid_s   = 1'b0;
    case (cmd_byte_s)
      8'h0B:   dec_dummy_s = 1'b1;
      8'h3B:   begin dec_dummy_s = 1'b1; dec_lanes_s = LANES_2; end
      8'h6B:   begin dec_dummy_s = 1'b1; dec_lanes_s = LANES_4; end
      8'h9F:   dec_rdid_s  = 1'b1;
      default: dec_dummy_s = 1'b0;
    endcase
    if (bus.spi_cs_in) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Only a genuine CS falling edge starts a transaction.
          if (cs_q_r) state_next_s = ST_CMD;
          else        state_next_s = ST_IDLE;
        end
        ST_CMD: begin
          if (sck_rise_s && bit_cnt_r == 3'd7) begin
            log_push_s = 1'b1;
            log_byte_s = cmd_byte_s;
            case (cmd_byte_s)
              8'h03, 8'h0B, 8'h3B, 8'h6B: state_next_s = ST_ADDR;
              8'h9F, 8'h05:               state_next_s = ST_RESP;
              default:                    state_next_s = ST_IGNORE;
            endcase
          end else begin
            state_next_s = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (sck_rise_s) begin
            if (addr_byte_done_s) begin
              log_push_s = 1'b1;
              log_byte_s = 8'(addr_next_s);
            end else begin
              log_push_s = 1'b0;
            end
            if (cnt_r == ADDR_LAST) begin
              if (dummy_r && DUMMY_CYCLES > 0) state_next_s = ST_DUMMY;
              else                             state_next_s = ST_DATA;
            end else begin
              state_next_s = ST_ADDR;
            end
          end else begin
            state_next_s = ST_ADDR;
          end
        end
        ST_DUMMY: begin
          if (sck_rise_s && cnt_r == DUMMY_LAST) state_next_s = ST_DATA;
          else                                   state_next_s = ST_DUMMY;
        end
        ST_DATA:   state_next_s = ST_DATA;
        ST_RESP:   state_next_s = ST_RESP;
        ST_IGNORE: state_next_s = ST_IGNORE;
        default:   state_next_s = ST_IDLE;
      endcase
    end
  end

  // Host-facing IO: bank passthrough in the data phase, response shifter in RESP.
  always_comb begin
    bank_slice_s = bus.bank_di[{bank_sel_r, 2'b00} +: 4];
    en_s         = 4'b0000;
    do_s         = 4'b0000;
    byte_last_s  = 3'd7;
    case (lanes_r)
      LANES_4: byte_last_s = 3'd1;
      LANES_2: byte_last_s = 3'd3;
      default: byte_last_s = 3'd7;
    endcase
    case (state_r)
      ST_DATA: begin
        case (lanes_r)
          LANES_4: en_s = 4'b1111;
          LANES_2: en_s = 4'b0011;
          default: en_s = 4'b0010;
        endcase
        do_s = bank_slice_s & en_s;
      end
      ST_RESP: begin
        en_s = 4'b0010;
        do_s = {2'b00, resp_sh_r[7], 1'b0};
      end
      default: begin
        en_s = 4'b0000;
        do_s = 4'b0000;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Shift registers, counters, address/bank tracking and response generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_clk_q_r <= 1'b0;
      cs_q_r      <= 1'b0;
      cmd_sh_r    <= 7'd0;
      bit_cnt_r   <= 3'd0;
      cnt_r       <= {CNT_W{1'b0}};
      read_addr_r <= {ADDR_BITS{1'b0}};
      bank_sel_r  <= {SEL_BITS{1'b0}};
      wel_r       <= 1'b0;
      dummy_r     <= 1'b0;
      rdid_r      <= 1'b0;
      lanes_r     <= LANES_1;
      resp_sh_r   <= 8'h00;
      resp_idx_r  <= 2'd0;
      resp_bit_r  <= 3'd0;
      resp_skip_r <= 1'b0;
    end else begin
      spi_clk_q_r <= bus.spi_clk;
      cs_q_r      <= bus.spi_cs_in;
      if (bus.spi_cs_in || state_r == ST_IDLE) begin
        bit_cnt_r <= 3'd0;
        cnt_r     <= {CNT_W{1'b0}};
      end else begin
        case (state_r)
          ST_CMD: begin
            if (sck_rise_s) begin
              cmd_sh_r  <= cmd_byte_s[6:0];
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                dummy_r     <= dec_dummy_s;
                lanes_r     <= dec_lanes_s;
                rdid_r      <= dec_rdid_s;
                cnt_r       <= {CNT_W{1'b0}};
                resp_sh_r   <= resp_byte(dec_rdid_s, 2'd0, wel_r);
                resp_idx_r  <= 2'd1;
                resp_bit_r  <= 3'd0;
                // First SCK fall after the opcode belongs to the command byte.
                resp_skip_r <= 1'b1;
                if (state_next_s == ST_ADDR) read_addr_r <= {ADDR_BITS{1'b0}};
                if (cmd_byte_s == 8'h06)      wel_r <= 1'b1;
                else if (cmd_byte_s == 8'h04) wel_r <= 1'b0;
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise_s) begin
              read_addr_r <= addr_next_s;
              if (cnt_r == ADDR_LAST) begin
                cnt_r      <= {CNT_W{1'b0}};
                bank_sel_r <= addr_next_s[ADDR_BITS-1 -: SEL_BITS];
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          ST_DUMMY: begin
            if (sck_rise_s) begin
              if (cnt_r == DUMMY_LAST) cnt_r <= {CNT_W{1'b0}};
              else                     cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (sck_rise_s) begin
              if (cnt_r == {{(CNT_W-3){1'b0}}, byte_last_s}) begin
                cnt_r       <= {CNT_W{1'b0}};
                read_addr_r <= addr_inc_s;
                bank_sel_r  <= addr_inc_s[ADDR_BITS-1 -: SEL_BITS];
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          ST_RESP: begin
            if (sck_fall_s) begin
              if (resp_skip_r) begin
                resp_skip_r <= 1'b0;
              end else if (resp_bit_r == 3'd7) begin
                resp_sh_r  <= resp_byte(rdid_r, resp_idx_r, wel_r);
                resp_bit_r <= 3'd0;
                if (resp_idx_r != 2'd3) resp_idx_r <= resp_idx_r + 2'd1;
              end else begin
                resp_sh_r  <= {resp_sh_r[6:0], 1'b0};
                resp_bit_r <= resp_bit_r + 3'd1;
              end
            end
          end
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[PTR_BITS] != rd_ptr_r[PTR_BITS]) &&
                     (wr_ptr_r[PTR_BITS-1:0] == rd_ptr_r[PTR_BITS-1:0]);
  assign pop_s     = ~empty_s & bus.log_ready;
  assign push_ok_s = log_push_s & (~full_s | pop_s);

  // Log FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r       <= {(PTR_BITS+1){1'b0}};
      rd_ptr_r       <= {(PTR_BITS+1){1'b0}};
      log_overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + (PTR_BITS+1)'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + (PTR_BITS+1)'(1);
      if (log_push_s && full_s && !pop_s) log_overflow_r <= 1'b1;
    end
  end

  // Log FIFO storage; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) log_mem_r[wr_ptr_r[PTR_BITS-1:0]] <= log_byte_s;
  end

  assign bus.spi_do        = do_s;
  assign bus.spi_do_enable = en_s;
  assign bus.bank_sel      = bank_sel_r;
  assign bus.log_data      = log_mem_r[rd_ptr_r[PTR_BITS-1:0]];
  assign bus.log_valid     = ~empty_s;
  assign bus.log_overflow  = log_overflow_r;
endmodule

// File: tb/tb_qspi_bank_router.sv
// Directed bench for qspi_bank_router: ID/status reads, WEL handling, bank
// routing across address wrap, log FIFO overflow and reset abort.
module tb_qspi_bank_router;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  qspi_bank_router_if #(.BANKS(2)) bus_if ();

  qspi_bank_router dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SCK period: data set while low, spi_do sampled just before the rise.
  task automatic sck_pulse(input logic [3:0] di, output logic [3:0] do_seen);
    bus_if.spi_di = di;
    tick(); tick();
    do_seen = bus_if.spi_do;
    bus_if.spi_clk = 1'b1;
    tick(); tick();
    bus_if.spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    logic [3:0] d;
    for (int i = n - 1; i >= 0; i--) sck_pulse({3'b000, val[i]}, d);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [3:0] d;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sck_pulse(4'h0, d);
      b = {b[6:0], d[1]};
    end
  endtask

  task automatic cs_begin();
    bus_if.spi_cs_in = 1'b0;
    tick(); tick();
  endtask

  task automatic cs_end();
    tick(); tick();
    bus_if.spi_cs_in = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] b);
    check_eq({tag, "_valid"}, 32'(bus_if.log_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(bus_if.log_data), 32'(b));
    bus_if.log_ready = 1'b1;
    tick();
    bus_if.log_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [3:0]  d;
    logic [23:0] addrs [5];
    logic [7:0]  exp_q [$];

    reset              = 1'b1;
    bus_if.spi_clk     = 1'b0;
    bus_if.spi_cs_in   = 1'b1;
    bus_if.spi_di      = 4'h0;
    bus_if.log_ready   = 1'b0;
    bus_if.bank_di     = {4'h5, 4'hA};   // bank1 = 5, bank0 = A
    repeat (3) tick();
    reset = 1'b0;
    tick(); tick();

    check_eq("rst_en",   32'(bus_if.spi_do_enable), 32'd0);
    check_eq("rst_do",   32'(bus_if.spi_do),        32'd0);
    check_eq("rst_bsel", 32'(bus_if.bank_sel),      32'd0);
    check_eq("rst_lv",   32'(bus_if.log_valid),     32'd0);
    check_eq("rst_ovf",  32'(bus_if.log_overflow),  32'd0);

    // RDID
    cs_begin();
    send_bits(32'h9F, 8);
    tick();
    check_eq("rdid_en", 32'(bus_if.spi_do_enable), 32'h2);
    read_byte(b); check_eq("rdid_b0", 32'(b), 32'hC2);
    read_byte(b); check_eq("rdid_b1", 32'(b), 32'h20);
    read_byte(b); check_eq("rdid_b2", 32'(b), 32'h18);
    read_byte(b); check_eq("rdid_b3", 32'(b), 32'h00);
    cs_end();
    check_eq("rdid_en_off", 32'(bus_if.spi_do_enable), 32'd0);
    pop_expect("rdid_log", 8'h9F);
    check_eq("rdid_log_empty", 32'(bus_if.log_valid), 32'd0);

    // WREN / RDSR / WRDI / RDSR
    cs_begin(); send_bits(32'h06, 8); cs_end();
    cs_begin(); send_bits(32'h05, 8); read_byte(b); cs_end();
    check_eq("rdsr_wel1", 32'(b), 32'h02);
    cs_begin(); send_bits(32'h04, 8); cs_end();
    cs_begin(); send_bits(32'h05, 8); read_byte(b); read_byte(b); cs_end();
    check_eq("rdsr_wel0", 32'(b), 32'h00);
    pop_expect("wel_log0", 8'h06);
    pop_expect("wel_log1", 8'h05);
    pop_expect("wel_log2", 8'h04);
    pop_expect("wel_log3", 8'h05);

    // READ across the bank boundary, 1 lane
    cs_begin();
    send_bits(32'h03, 8);
    send_bits(32'h7FFFFF, 24);
    tick();
    check_eq("rd1_en",   32'(bus_if.spi_do_enable), 32'h2);
    check_eq("rd1_bsel", 32'(bus_if.bank_sel),      32'd0);
    for (int i = 0; i < 16; i++) begin
      sck_pulse(4'h0, d);
      if (i == 0) check_eq("rd1_byte0_first", 32'(d), 32'h2);
      if (i == 7) check_eq("rd1_byte0_last",  32'(d), 32'h2);
      if (i == 8) check_eq("rd1_byte1_first", 32'(d), 32'h0);
      if (i == 15) check_eq("rd1_byte1_last", 32'(d), 32'h0);
    end
    tick();
    check_eq("rd1_bsel_end", 32'(bus_if.bank_sel), 32'd1);
    cs_end();
    pop_expect("rd1_log0", 8'h03);
    pop_expect("rd1_log1", 8'h7F);
    pop_expect("rd1_log2", 8'hFF);
    pop_expect("rd1_log3", 8'hFF);

    // Quad read at the top of memory, wrapping to bank 0
    cs_begin();
    send_bits(32'h6B, 8);
    send_bits(32'hFFFFFF, 24);
    tick();
    check_eq("q_dummy_en", 32'(bus_if.spi_do_enable), 32'd0);
    send_bits(32'h0, 8);
    tick();
    check_eq("q_en",   32'(bus_if.spi_do_enable), 32'hF);
    check_eq("q_bsel", 32'(bus_if.bank_sel),      32'd1);
    for (int i = 0; i < 4; i++) begin
      sck_pulse(4'h0, d);
      if (i < 2) check_eq("q_bank1", 32'(d), 32'h5);
      else       check_eq("q_bank0", 32'(d), 32'hA);
    end
    tick();
    check_eq("q_bsel_wrap", 32'(bus_if.bank_sel), 32'd0);
    cs_end();
    pop_expect("q_log0", 8'h6B);
    pop_expect("q_log1", 8'hFF);
    pop_expect("q_log2", 8'hFF);
    pop_expect("q_log3", 8'hFF);

    // CS abort during address
    cs_begin();
    send_bits(32'h03, 8);
    send_bits(32'h15, 5);
    bus_if.spi_cs_in = 1'b1;
    tick();
    check_eq("abort_en", 32'(bus_if.spi_do_enable), 32'd0);
    tick(); tick();
    pop_expect("abort_log", 8'h03);
    check_eq("abort_log_empty", 32'(bus_if.log_valid), 32'd0);

    // Set WEL so the later reset is observable, then fill the log past capacity
    cs_begin(); send_bits(32'h06, 8); cs_end();
    pop_expect("wren_log", 8'h06);
    check_eq("pre_ovf", 32'(bus_if.log_overflow), 32'd0);
    addrs[0] = 24'h123456; addrs[1] = 24'h00ABCD; addrs[2] = 24'h800001;
    addrs[3] = 24'h55AA33; addrs[4] = 24'h9ABCDE;
    for (int k = 0; k < 5; k++) begin
      cs_begin();
      send_bits(32'h03, 8);
      send_bits(32'(addrs[k]), 24);
      cs_end();
      exp_q.push_back(8'h03);
      exp_q.push_back(addrs[k][23:16]);
      exp_q.push_back(addrs[k][15:8]);
      exp_q.push_back(addrs[k][7:0]);
    end
    check_eq("ovf_set", 32'(bus_if.log_overflow), 32'd1);
    for (int k = 0; k < 16; k++) pop_expect($sformatf("ovf_drain%0d", k), exp_q[k]);
    check_eq("ovf_drained", 32'(bus_if.log_valid), 32'd0);
    check_eq("ovf_sticky",  32'(bus_if.log_overflow), 32'd1);
    check_eq("pre_rst_bsel", 32'(bus_if.bank_sel), 32'd1);

    // Reset mid-transaction, CS kept low throughout
    cs_begin();
    send_bits(32'h03, 8);
    send_bits(32'h5, 3);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("mrst_ovf",  32'(bus_if.log_overflow),  32'd0);
    check_eq("mrst_lv",   32'(bus_if.log_valid),     32'd0);
    check_eq("mrst_en",   32'(bus_if.spi_do_enable), 32'd0);
    check_eq("mrst_bsel", 32'(bus_if.bank_sel),      32'd0);
    send_bits(32'h9F, 8);
    tick();
    check_eq("mrst_nocmd_lv", 32'(bus_if.log_valid),     32'd0);
    check_eq("mrst_nocmd_en", 32'(bus_if.spi_do_enable), 32'd0);
    cs_end();
    cs_begin(); send_bits(32'h05, 8); read_byte(b); cs_end();
    check_eq("mrst_wel", 32'(b), 32'h00);
    pop_expect("mrst_log", 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qspi_bank_router.md
QSPI_BANK_ROUTER -- requirements
Module: qspi_bank_router

Interface
REQ-001 Parameter ADDR_BITS, default 24: SPI address width.
REQ-002 Parameter BANKS, default 2, power of two >= 2: number of RAM banks; SEL_BITS = log2(BANKS).
REQ-003 Parameter JEDEC_ID, default 24'hC22018: RDID response.
REQ-004 Parameter DUMMY_CYCLES, default 8: SCK cycles between address and data for 0x0B/0x3B/0x6B.
REQ-005 Parameter LOG_DEPTH, default 16, power of two: log FIFO entries.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 spi_clk  in  1  SPI SCK, already synchronised to clk upstream.
REQ-010 spi_cs_in  in  1  SPI chip select, active low, already synchronised.
REQ-011 spi_di  in  4  SPI IO[3:0] from host, already synchronised.
REQ-012 spi_do  out  4  SPI IO[3:0] toward host.
REQ-013 spi_do_enable  out  4  per-lane output enable toward host.
REQ-014 bank_di  in  4*BANKS  IO[3:0] from each bank; bank k at [4k+3:4k].
REQ-015 bank_sel  out  SEL_BITS  selected bank index.
REQ-016 log_data  out  8  logged byte; log_valid out 1; log_ready in 1: valid/ready stream.
REQ-017 log_overflow  out  1  sticky flag, a log byte was dropped.

Function
REQ-018 SHALL detect SCK rise/fall by comparing spi_clk with its value registered on the previous clk; spi_clk frequency SHALL be at most clk/4.
REQ-019 States: IDLE, CMD, ADDR, DUMMY, DATA, RESP, IGNORE; spi_cs_in high in any state SHALL force IDLE on the next clk, clear spi_do_enable, discard partial byte (not logged).
REQ-020 IDLE -> CMD on spi_cs_in low; CMD shifts spi_di[0] MSB first on each SCK rise; after 8 bits decode.
REQ-021 0x03 -> ADDR, no dummy, 1 lane; 0x0B -> ADDR, dummy, 1 lane; 0x3B -> dummy, 2 lanes; 0x6B -> dummy, 4 lanes.
REQ-022 0x9F, 0x05 -> RESP; 0x06 sets WEL, 0x04 clears WEL, both -> IGNORE; any other opcode -> IGNORE.
REQ-023 ADDR shifts spi_di[0] for ADDR_BITS SCK rises MSB first into read_addr, then DUMMY (counting DUMMY_CYCLES rises) or DATA.
REQ-024 DATA: spi_do = bank_di slice of bank_sel, combinational; spi_do_enable = 4'b0010 / 4'b0011 / 4'b1111 for 1/2/4 lanes.
REQ-025 bank_sel = read_addr[ADDR_BITS-1 -: SEL_BITS], updated only at byte boundaries.
REQ-026 DATA: byte boundary every 8/4/2 SCK rises for 1/2/4 lanes; read_addr increments by 1 per byte, wrapping from all-ones to 0.
REQ-027 RESP: spi_do[1] driven from an 8-bit shift register MSB first, spi_do_enable = 4'b0010; first bit valid on the clk after the 8th command SCK rise; shift on each SCK fall.
REQ-028 RDID bytes: JEDEC_ID[23:16], [15:8], [7:0], then 8'h00 repeating.
REQ-029 RDSR byte: {6'b0, WEL, 1'b0}, repeated for every byte.
REQ-030 spi_do bits not enabled SHALL be 0.
REQ-031 Log: every complete command byte and every complete address byte (MSB byte first, ceil(ADDR_BITS/8) bytes, top byte zero-padded) SHALL be pushed into the FIFO; data-phase bytes are not logged.
REQ-032 Push when FIFO full SHALL drop the byte and set log_overflow; log_overflow clears only on reset.
REQ-033 log_valid high while FIFO non-empty; pop on log_valid & log_ready; simultaneous push and pop when full SHALL accept both.

Reset
REQ-034 Reset SHALL give: state IDLE, spi_do 0, spi_do_enable 0, bank_sel 0, read_addr 0, WEL 0, FIFO empty, log_valid 0, log_overflow 0.
REQ-035 Reset mid-transaction SHALL abort it; next activity requires a fresh spi_cs_in falling.

Verification
REQ-036 Bench: 0x9F then 24 SCK -> host reads C2 20 18, spi_do_enable 4'b0010; log holds 0x9F only.
REQ-037 Bench: 0x06, CS high, 0x05 + 8 SCK -> 0x02; then 0x04, 0x05 -> 0x00.
REQ-038 Bench: 0x03 addr 0x7FFFFF, 16 data SCK, banks drive distinct patterns -> byte0 from bank 0, byte1 from bank 1 (addr 0x800000); log 03 7F FF FF.
REQ-039 Bench: 0x6B addr 0xFFFFFF, 8 dummy, 4 SCK -> spi_do_enable 4'b1111, bank 1 then bank 0 after wrap to 0x000000.
REQ-040 Bench: log_ready 0, 5 READ commands (20 bytes) -> 16 entries kept, log_overflow 1; drain gives first 16 bytes in order.
REQ-041 Bench: CS raised after 5 address bits of 0x03 -> spi_do_enable 0 next clk, 0x03 logged, no address byte logged.
